lap_gate: RTL and testbench

- Front-end stage between the raw laser_detector pin and the lap timer / five-second logic.
- Synchronises and debounces the beam input, then turns beam-break events into start, lap and timer-reset controls.
- Enforces a minimum-lap holdoff and requires the beam to be restored before the next break is accepted.
- Downstream latches each finished lap on lap_strobe, while the timer still holds the finished lap time.

---
 rtl/lap_pkg.sv | 13 +
 rtl/lap_debounce.sv | 45 ++++
 rtl/lap_gate.sv | 96 +++++++++
 tb/tb_lap_gate.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lap_pkg.sv
// rtl/lap_pkg.sv - shared state type, field widths and counter helper for the lap gate
package lap_pkg;

  localparam int LAP_CNT_W = 8;
  localparam int TIME_W    = 7;

  typedef enum logic [1:0] {IDLE, HOLDOFF, WAIT_CLEAR, ARMED} lap_state_t;

  function automatic logic [LAP_CNT_W-1:0] sat_inc(input logic [LAP_CNT_W-1:0] v);
    return (v == {LAP_CNT_W{1'b1}}) ? v : v + LAP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/lap_debounce.sv
// rtl/lap_debounce.sv - synchronise and debounce the detector pin, flag clear->broken edges
module lap_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DET_ACTIVE_LOW  = 1
) (
  input  logic master_clk,
  input  logic rs,
  input  logic raw,
  output logic level,
  output logic break_evt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   sample;

  // sample is 1 when the beam is broken, regardless of pin polarity
  assign sample = (DET_ACTIVE_LOW != 0) ? ~sync[SYNC_STAGES-1] : sync[SYNC_STAGES-1];

  always_ff @(posedge master_clk) begin
    if (rs) begin
      sync      <= '0;
      cnt       <= '0;
      level     <= 1'b0;
      break_evt <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], raw};
      break_evt <= 1'b0;
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt       <= '0;
        level     <= sample;
        break_evt <= sample;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lap_gate.sv
// rtl/lap_gate.sv - beam-break front end: start/lap/timeout FSM, lap counter, timer pulses
module lap_gate
  import lap_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLDOFF_SEC     = 5,
  parameter int DET_ACTIVE_LOW  = 1,
  parameter int MAX_MIN         = 99
) (
  input  logic                 master_clk,
  input  logic                 rs,
  input  logic                 laser_detector,
  input  logic [TIME_W-1:0]    seconds,
  input  logic [TIME_W-1:0]    minutes,
  output logic                 timer_en,
  output logic                 timer_rs,
  output logic                 lap_strobe,
  output logic [LAP_CNT_W-1:0] lap_count,
  output logic                 armed,
  output logic                 timeout
);

  lap_state_t state, state_nxt;
  logic level, break_evt;
  logic pend_rs;
  logic time_valid, start, lap, to_timeout, holdoff_done;
  logic en_nxt, trs_nxt, strobe_nxt, armed_nxt, timeout_nxt, pend_nxt;
  logic [LAP_CNT_W-1:0] cnt_nxt;

  lap_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DET_ACTIVE_LOW (DET_ACTIVE_LOW)
  ) u_debounce (
    .master_clk(master_clk),
    .rs        (rs),
    .raw       (laser_detector),
    .level     (level),
    .break_evt (break_evt)
  );

  // seconds/minutes still show the previous run until the requested clear has landed
  assign time_valid   = !timer_rs && !pend_rs;
  assign holdoff_done = time_valid && ((minutes != '0) || (seconds >= TIME_W'(HOLDOFF_SEC)));
  assign to_timeout   = (state != IDLE) && time_valid && (minutes >= TIME_W'(MAX_MIN));
  assign start        = (state == IDLE) && break_evt;
  assign lap          = (state == ARMED) && break_evt && !to_timeout;

  always_ff @(posedge master_clk) begin
    if (rs) begin
      state      <= IDLE;
      timer_en   <= 1'b0;
      timer_rs   <= 1'b0;
      lap_strobe <= 1'b0;
      lap_count  <= '0;
      armed      <= 1'b0;
      timeout    <= 1'b0;
      pend_rs    <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer_en   <= en_nxt;
      timer_rs   <= trs_nxt;
      lap_strobe <= strobe_nxt;
      lap_count  <= cnt_nxt;
      armed      <= armed_nxt;
      timeout    <= timeout_nxt;
      pend_rs    <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (break_evt) state_nxt = HOLDOFF;
      HOLDOFF:    if (holdoff_done) state_nxt = level ? WAIT_CLEAR : ARMED;
      WAIT_CLEAR: if (!level) state_nxt = ARMED;
      ARMED:      if (break_evt) state_nxt = HOLDOFF;
      default:    state_nxt = IDLE;
    endcase
    if (to_timeout) state_nxt = IDLE;
  end

  always_comb begin
    en_nxt      = (state_nxt != IDLE);
    trs_nxt     = start || pend_rs;
    strobe_nxt  = lap;
    pend_nxt    = lap;
    cnt_nxt     = lap ? sat_inc(lap_count) : lap_count;
    armed_nxt   = (state_nxt == ARMED);
    timeout_nxt = timeout;
    if (to_timeout) timeout_nxt = 1'b1;
    else if (start) timeout_nxt = 1'b0;
  end

endmodule

// File: tb/tb_lap_gate.sv
// tb/tb_lap_gate.sv - directed self-checking bench for lap_gate
module tb_lap_gate;

  logic       master_clk = 1'b0;
  logic       rs = 1'b1;
  logic       laser_detector = 1'b1;
  logic [6:0] seconds = '0;
  logic [6:0] minutes = '0;
  logic       timer_en, timer_rs, lap_strobe, armed, timeout;
  logic [7:0] lap_count;

  int n_checks = 0;
  int n_fail = 0;
  int n_trs = 0;
  int n_ls = 0;
  int n_both = 0;
  int n_wide = 0;
  logic prev_trs = 1'b0;
  logic prev_ls = 1'b0;
  int snap;

  lap_gate #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLDOFF_SEC(5), .DET_ACTIVE_LOW(1), .MAX_MIN(99)
  ) dut (
    .master_clk(master_clk), .rs(rs), .laser_detector(laser_detector),
    .seconds(seconds), .minutes(minutes), .timer_en(timer_en), .timer_rs(timer_rs),
    .lap_strobe(lap_strobe), .lap_count(lap_count), .armed(armed), .timeout(timeout)
  );

  always #5 master_clk = ~master_clk;

  always @(negedge master_clk) begin
    if (timer_rs) n_trs++;
    if (lap_strobe) n_ls++;
    if (timer_rs && lap_strobe) n_both++;
    if ((timer_rs && prev_trs) || (lap_strobe && prev_ls)) n_wide++;
    prev_trs = timer_rs;
    prev_ls = lap_strobe;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge master_clk);
    #1;
  endtask

  task automatic do_reset();
    rs = 1'b1; laser_detector = 1'b1; seconds = '0; minutes = '0;
    tick(2);
    rs = 1'b0;
    tick(4);
  endtask

  // low for 8 cycles, then beam restored and given 8 cycles to settle clear
  task automatic pulse_break();
    laser_detector = 1'b0;
    tick(8);
    laser_detector = 1'b1;
    tick(8);
  endtask

  task automatic test_reset();
    rs = 1'b1; laser_detector = 1'b1;
    tick(2);
    n_checks++;
    if ({timer_en, timer_rs, lap_strobe, armed, timeout} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {timer_en, timer_rs, lap_strobe, armed, timeout});
    end
    n_checks++;
    if (lap_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", lap_count);
    end
    rs = 1'b0;
    tick(6);
    n_checks++;
    if ({timer_en, timer_rs, armed} !== 3'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got %b expected 000", {timer_en, timer_rs, armed});
    end
  endtask

  task automatic test_first_break();
    do_reset();
    snap = n_trs;
    laser_detector = 1'b0;
    tick(6);
    n_checks++;
    if (timer_rs !== 1'b0) begin
      n_fail++; $display("FAIL start_early: timer_rs got %b expected 0", timer_rs);
    end
    tick(1);
    n_checks++;
    if ({timer_rs, timer_en, armed} !== 3'b110 || lap_count !== 8'd0) begin
      n_fail++; $display("FAIL start_pulse: rs/en/armed got %b expected 110, count got %0d expected 0", {timer_rs, timer_en, armed}, lap_count);
    end
    tick(3);
    laser_detector = 1'b1;
    tick(8);
    n_checks++;
    if (n_trs - snap !== 1 || timer_en !== 1'b1) begin
      n_fail++; $display("FAIL start_single: pulses got %0d expected 1, timer_en got %b expected 1", n_trs - snap, timer_en);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    snap = n_trs;
    for (int w = 1; w <= 3; w++) begin
      laser_detector = 1'b0;
      tick(w);
      laser_detector = 1'b1;
      tick(8);
    end
    n_checks++;
    if (n_trs - snap !== 0 || timer_en !== 1'b0) begin
      n_fail++; $display("FAIL glitch_reject: pulses got %0d expected 0, timer_en got %b expected 0", n_trs - snap, timer_en);
    end
    laser_detector = 1'b0;
    tick(4);
    laser_detector = 1'b1;
    tick(10);
    n_checks++;
    if (n_trs - snap !== 1 || timer_en !== 1'b1) begin
      n_fail++; $display("FAIL glitch_4cyc: pulses got %0d expected 1, timer_en got %b expected 1", n_trs - snap, timer_en);
    end
  endtask

  task automatic test_holdoff();
    do_reset();
    pulse_break();
    seconds = 7'd3;
    snap = n_trs;
    pulse_break();
    n_checks++;
    if (n_trs - snap !== 0 || n_ls !== 0 || armed !== 1'b0) begin
      n_fail++; $display("FAIL holdoff_ignore: trs %0d ls %0d armed %b expected 0 0 0", n_trs - snap, n_ls, armed);
    end
    seconds = 7'd5;
    tick(1);
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++; $display("FAIL holdoff_arm: armed got %b expected 1", armed);
    end
    laser_detector = 1'b0;
    tick(6);
    n_checks++;
    if (lap_strobe !== 1'b0) begin
      n_fail++; $display("FAIL lap_early: lap_strobe got %b expected 0", lap_strobe);
    end
    tick(1);
    n_checks++;
    if ({lap_strobe, timer_rs, armed} !== 3'b100 || lap_count !== 8'd1) begin
      n_fail++; $display("FAIL lap_strobe: strobe/rs/armed got %b expected 100, count got %0d expected 1", {lap_strobe, timer_rs, armed}, lap_count);
    end
    tick(1);
    n_checks++;
    if ({lap_strobe, timer_rs, timer_en} !== 3'b011) begin
      n_fail++; $display("FAIL lap_clear: strobe/rs/en got %b expected 011", {lap_strobe, timer_rs, timer_en});
    end
    tick(1);
    n_checks++;
    if (timer_rs !== 1'b0) begin
      n_fail++; $display("FAIL lap_clear_width: timer_rs got %b expected 0", timer_rs);
    end
    laser_detector = 1'b1;
    tick(8);
  endtask

  task automatic test_wait_clear();
    do_reset();
    pulse_break();
    seconds = 7'd3;
    laser_detector = 1'b0;
    tick(8);
    seconds = 7'd7;
    tick(3);
    n_checks++;
    if (armed !== 1'b0 || timer_en !== 1'b1) begin
      n_fail++; $display("FAIL wait_clear_hold: armed got %b expected 0, en got %b expected 1", armed, timer_en);
    end
    laser_detector = 1'b1;
    tick(6);
    n_checks++;
    if (armed !== 1'b0) begin
      n_fail++; $display("FAIL wait_clear_early: armed got %b expected 0", armed);
    end
    tick(1);
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++; $display("FAIL wait_clear_arm: armed got %b expected 1", armed);
    end
  endtask

  task automatic test_saturation();
    snap = n_ls;
    for (int i = 0; i < 300; i++) begin
      pulse_break();
      if (i == 254) begin
        n_checks++;
        if (lap_count !== 8'd255) begin
          n_fail++; $display("FAIL sat_reach: lap_count got %0d expected 255", lap_count);
        end
      end
    end
    n_checks++;
    if (lap_count !== 8'd255 || n_ls - snap !== 300) begin
      n_fail++; $display("FAIL sat_hold: count got %0d expected 255, strobes got %0d expected 300", lap_count, n_ls - snap);
    end
    n_checks++;
    if (n_both !== 0 || n_wide !== 0) begin
      n_fail++; $display("FAIL pulse_shape: overlap got %0d wide got %0d expected 0 0", n_both, n_wide);
    end
  endtask

  task automatic test_timeout_vs_break();
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++; $display("FAIL timeout_setup: armed got %b expected 1", armed);
    end
    snap = n_ls;
    laser_detector = 1'b0;
    tick(6);
    minutes = 7'd99;
    tick(1);
    n_checks++;
    if ({timeout, timer_en, lap_strobe, armed} !== 4'b1000) begin
      n_fail++; $display("FAIL timeout_wins: to/en/strobe/armed got %b expected 1000", {timeout, timer_en, lap_strobe, armed});
    end
    tick(4);
    n_checks++;
    if (n_ls - snap !== 0 || timeout !== 1'b1 || lap_count !== 8'd255) begin
      n_fail++; $display("FAIL timeout_sticky: strobes %0d to %b count %0d expected 0 1 255", n_ls - snap, timeout, lap_count);
    end
    minutes = '0;
    laser_detector = 1'b1;
    tick(8);
  endtask

  task automatic test_abort();
    do_reset();
    pulse_break();
    seconds = 7'd7;
    tick(2);
    laser_detector = 1'b0;
    tick(7);
    n_checks++;
    if (lap_strobe !== 1'b1) begin
      n_fail++; $display("FAIL abort_setup: lap_strobe got %b expected 1", lap_strobe);
    end
    snap = n_trs;
    rs = 1'b1;
    laser_detector = 1'b1;
    tick(1);
    n_checks++;
    if ({timer_en, timer_rs, lap_strobe, armed, timeout} !== 5'b0 || lap_count !== 8'd0) begin
      n_fail++; $display("FAIL abort_clear: flags got %b count %0d expected 00000 0", {timer_en, timer_rs, lap_strobe, armed, timeout}, lap_count);
    end
    rs = 1'b0;
    tick(8);
    n_checks++;
    if (n_trs - snap !== 0 || timer_en !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_rs: timer_rs pulses got %0d expected 0, en got %b expected 0", n_trs - snap, timer_en);
    end
  endtask

  initial begin
    test_reset();
    test_first_break();
    test_glitch();
    test_holdoff();
    test_wait_clear();
    test_saturation();
    test_timeout_vs_break();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
